// File: rtl/mips_pkg.sv
// Shared MIPS CPU constants: datapath width, NOP encoding and the default
// depth of the instruction fetch queue.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int FETCH_QUEUE_DEPTH = 4;

endpackage : mips_pkg

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue. The master side is the
// fetch/decode pipeline and the slave side is the queue itself.
interface fetch_queue_if #(
  parameter int DEPTH  = mips_pkg::FETCH_QUEUE_DEPTH,
  parameter int DATA_W = mips_pkg::DATA_W
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] PC_in;
  logic [DATA_W-1:0] Instr_in;
  logic              Push;
  logic              Full;
  logic              Pop;
  logic              Valid;
  logic [DATA_W-1:0] PC_out;
  logic [DATA_W-1:0] Instr_out;
  logic              Flush;
  logic [CNT_W-1:0]  Count;

  modport master (
    output PC_in, Instr_in, Push, Pop, Flush,
    input  Full, Valid, PC_out, Instr_out, Count
  );

  modport slave (
    input  PC_in, Instr_in, Push, Pop, Flush,
    output Full, Valid, PC_out, Instr_out, Count
  );

endinterface : fetch_queue_if

// File: rtl/fetch_queue_mem.sv
// Storage array for fetch_queue: DEPTH entries of {PC, instr}, one write port
// and one asynchronous read port.
module fetch_queue_mem #(
  parameter int DEPTH = mips_pkg::FETCH_QUEUE_DEPTH,
  parameter int WIDTH = 2 * mips_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; occupancy lives in the counter, so stale
  // entries are never observed and the storage stays plain flops.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// In-order {PC, instr} queue between fetch and decode; Full gates PC enable.
// Define FETCH_QUEUE_BYPASS_EN to let a push into an empty queue show same-cycle.
module fetch_queue #(
  parameter int DEPTH  = mips_pkg::FETCH_QUEUE_DEPTH,
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic          CLK,
  input  logic          RST,
  fetch_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [2*DATA_W-1:0] head_entry;
  logic                empty, full, valid;
  logic                bypass, bypass_consume;
  logic                wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && bus.Push && !bus.Flush;
`else
  assign bypass = 1'b0;
`endif

  assign valid          = !empty || bypass;
  assign bypass_consume = bypass && bus.Pop;
  // A bypassed pair popped in the same cycle never touches storage.
  assign wr_en = bus.Push && !full && !bus.Flush && !bypass_consume;
  assign rd_en = bus.Pop && valid && !bus.Flush && !bypass_consume;

  // NOTE: every next-state signal takes its current value first, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs.
  always_ff @(posedge CLK) begin
    if (RST || bus.Flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_mem (
    .clk     (CLK),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({bus.PC_in, bus.Instr_in}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  always_comb begin
    bus.PC_out    = '0;
    bus.Instr_out = DATA_W'(mips_pkg::NOP_INSTR);
    if (!empty) begin
      bus.PC_out    = head_entry[2*DATA_W-1:DATA_W];
      bus.Instr_out = head_entry[DATA_W-1:0];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (bypass) begin
      bus.PC_out    = bus.PC_in;
      bus.Instr_out = bus.Instr_in;
    end
`endif
  end

  assign bus.Valid = valid;
  assign bus.Full  = full;
  assign bus.Count = count_q;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: accepted pushes enter a reference queue
// and every cycle the DUT head, flags and occupancy are compared against it.
module tb_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic CLK;
  logic RST;
  int   n_vec = 0;
  int   n_err = 0;
  entry_t exp_q[$];

  fetch_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h2008_0001 + (pc >> 2);
  endfunction

  // Drives one cycle of stimulus at the falling edge, checks the DUT outputs
  // against the reference queue, then advances the reference for the next edge.
  task automatic step(input logic push, input logic [31:0] pc,
                      input logic pop, input logic flush);
    int          n;
    logic        exp_valid;
    logic [31:0] exp_pc, exp_instr, instr;
    @(negedge CLK);
    instr        = instr_of(pc);
    bus.Push     = push;
    bus.PC_in    = pc;
    bus.Instr_in = instr;
    bus.Pop      = pop;
    bus.Flush    = flush;
    #1;
    n         = exp_q.size();
    exp_valid = (n != 0) || (BYP && push && !flush);
    if (n != 0) begin
      exp_pc    = exp_q[0].pc;
      exp_instr = exp_q[0].instr;
    end else if (exp_valid) begin
      exp_pc    = pc;
      exp_instr = instr;
    end else begin
      exp_pc    = 32'h0;
      exp_instr = 32'h0;
    end
    check("valid",     64'(bus.Valid),     64'(exp_valid));
    check("full",      64'(bus.Full),      64'(n == DEPTH));
    check("count",     64'(bus.Count),     64'(n));
    check("pc_out",    64'(bus.PC_out),    64'(exp_pc));
    check("instr_out", 64'(bus.Instr_out), 64'(exp_instr));
    if (flush) begin
      exp_q.delete();
    end else if (!(n == 0 && exp_valid && pop)) begin
      if (pop && n != 0) void'(exp_q.pop_front());
      if (push && n != DEPTH) exp_q.push_back('{pc: pc, instr: instr});
    end
  endtask

  initial begin
    logic [31:0] pc_next;
    RST          = 1'b1;
    bus.Push     = 1'b0;
    bus.Pop      = 1'b0;
    bus.Flush    = 1'b0;
    bus.PC_in    = '0;
    bus.Instr_in = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();

    // Reset then idle.
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Fill to DEPTH, a refused 5th push, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
    step(1'b1, 32'h10, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Simultaneous push/pop at Count=2; pointers wrap twice.
    step(1'b1, 32'h80, 1'b0, 1'b0);
    step(1'b1, 32'h84, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 32'h88 + 32'(i * 4), 1'b1, 1'b0);

    // Fill, then push with pop while Full: pop only, Count drops to 3.
    step(1'b1, 32'hA8, 1'b0, 1'b0);
    step(1'b1, 32'hAC, 1'b0, 1'b0);
    step(1'b1, 32'hB0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Flush at Count=3 with a push; then a fresh push reaches the head.
    step(1'b1, 32'hB4, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Push with pop into an empty queue (bypass-dependent outcome).
    step(1'b1, 32'h100, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h104, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    pc_next = 32'h200;
    for (int i = 0; i < 120; i++) begin
      step(1'($urandom_range(0, 1)), pc_next, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
      pc_next += 32'h4;
    end

    // Reset mid-stream clears occupancy.
    step(1'b1, 32'h300, 1'b0, 1'b0);
    @(negedge CLK);
    RST      = 1'b1;
    bus.Push = 1'b0;
    bus.Pop  = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    step(1'b0, 32'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fetch_queue
